// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for the pipeline and the stage.
interface execute_stage_if;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] SignImmE;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  RdE;
  logic [4:0]  ShamtE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic [2:0]  MdOpE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;

  logic [4:0]  WriteRegE;
  logic        StallE;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;

  // RsE is only consumed by the hazard unit, so the stage itself does not take it.
  modport master (
    output RD1E, RD2E, SignImmE, RsE, RtE, RdE, ShamtE, ALUControlE, ALUSrcE, RegDstE,
           RegWriteE, MemtoRegE, MemWriteE, MdOpE, ForwardAE, ForwardBE, ResultW,
    input  WriteRegE, StallE, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM
  );

  modport slave (
    input  RD1E, RD2E, SignImmE, RtE, RdE, ShamtE, ALUControlE, ALUSrcE, RegDstE,
           RegWriteE, MemtoRegE, MemWriteE, MdOpE, ForwardAE, ForwardBE, ResultW,
    output WriteRegE, StallE, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding, 1-cycle ALU, 33-cycle iterative mult/div with HI/LO, EX/MEM register.
// StallE holds the front of the pipe while mult/div runs; stalled cycles push bubbles into MEM.
module execute_stage (
  input  logic          clk,
  input  logic          rst_n,
  execute_stage_if.slave ex
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;

  md_state_t   state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] oprnd;
  logic        md_div;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] srca;
  logic [31:0] srcb_fwd;
  logic [31:0] srcb;
  logic [31:0] alu_y;
  logic [31:0] ex_result;
  logic        is_md;
  logic        is_mf;
  logic        op_signed;
  logic        sa;
  logic        sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    return (sel == 2'b01) ? wb : (sel == 2'b10) ? mem : rf;
  endfunction

  assign srca     = fwd_sel(ex.ForwardAE, ex.RD1E, ex.ResultW, ex.ALUOutM);
  assign srcb_fwd = fwd_sel(ex.ForwardBE, ex.RD2E, ex.ResultW, ex.ALUOutM);
  assign srcb     = ex.ALUSrcE ? ex.SignImmE : srcb_fwd;

  always_comb begin
    alu_y = '0;
    case (ex.ALUControlE)
      4'b0000: alu_y = srca & srcb;
      4'b0001: alu_y = srca | srcb;
      4'b0010: alu_y = srca + srcb;
      4'b0011: alu_y = srca ^ srcb;
      4'b0100: alu_y = ~(srca | srcb);
      4'b0110: alu_y = srca - srcb;
      4'b0111: alu_y = {31'd0, $signed(srca) < $signed(srcb)};
      4'b1000: alu_y = {31'd0, srca < srcb};
      4'b1001: alu_y = srcb << ex.ShamtE;
      4'b1010: alu_y = srcb >> ex.ShamtE;
      4'b1011: alu_y = $unsigned($signed(srcb) >>> ex.ShamtE);
      4'b1100: alu_y = {srcb[15:0], 16'h0000};
      default: alu_y = '0;
    endcase
  end

  assign is_md     = (ex.MdOpE == MD_MULT) || (ex.MdOpE == MD_MULTU) ||
                     (ex.MdOpE == MD_DIV)  || (ex.MdOpE == MD_DIVU);
  assign is_mf     = (ex.MdOpE == MD_MFHI) || (ex.MdOpE == MD_MFLO);
  assign op_signed = (ex.MdOpE == MD_MULT) || (ex.MdOpE == MD_DIV);
  assign sa        = op_signed & srca[31];
  assign sb        = op_signed & srcb_fwd[31];
  assign mag_a     = sa ? -srca : srca;
  assign mag_b     = sb ? -srcb_fwd : srcb_fwd;

  assign ex.WriteRegE = ex.RegDstE ? ex.RdE : ex.RtE;
  assign ex.StallE    = ((state == S_IDLE) && is_md) || (state == S_BUSY) ||
                        (is_mf && (state != S_IDLE));

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] acc_next;
  logic [63:0] prod;
  logic [31:0] hi_fin;
  logic [31:0] lo_fin;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, oprnd} : 33'd0);
    div_part = acc[63:31];
    div_ge   = div_part >= {1'b0, oprnd};
    div_diff = div_part[31:0] - oprnd;
    if (md_div)
      acc_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_next = {mul_sum, acc[31:1]};
    prod = neg_q ? -acc_next : acc_next;
    if (md_div) begin
      lo_fin = div0 ? 32'hFFFF_FFFF : (neg_q ? -acc_next[31:0] : acc_next[31:0]);
      hi_fin = neg_r ? -acc_next[63:32] : acc_next[63:32];
    end else begin
      lo_fin = prod[31:0];
      hi_fin = prod[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      oprnd  <= '0;
      md_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_md) begin
            acc    <= {32'd0, mag_a};
            oprnd  <= mag_b;
            md_div <= (ex.MdOpE == MD_DIV) || (ex.MdOpE == MD_DIVU);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= (srcb_fwd == 32'd0);
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= acc_next;
          if (cnt == 5'd31) begin
            hi    <= hi_fin;
            lo    <= lo_fin;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        // The stalled mult/div retires here; returning to IDLE without re-issuing it.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_result = (ex.MdOpE == MD_MFHI) ? hi : (ex.MdOpE == MD_MFLO) ? lo : alu_y;

  always_ff @(posedge clk) begin
    if (!rst_n || ex.StallE) begin
      ex.ALUOutM    <= '0;
      ex.WriteDataM <= '0;
      ex.WriteRegM  <= '0;
      ex.RegWriteM  <= 1'b0;
      ex.MemtoRegM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
    end else begin
      ex.ALUOutM    <= ex_result;
      ex.WriteDataM <= srcb_fwd;
      ex.WriteRegM  <= ex.WriteRegE;
      ex.RegWriteM  <= ex.RegWriteE && !is_md;
      ex.MemtoRegM  <= ex.MemtoRegE;
      ex.MemWriteM  <= ex.MemWriteE;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table plus hand-written forwarding, mult/div and reset sequences.
module tb_execute_stage;
  logic clk;
  logic rst_n;
  execute_stage_if bus();

  execute_stage dut (.clk(clk), .rst_n(rst_n), .ex(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int bubble_bad = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.RD1E = '0; bus.RD2E = '0; bus.SignImmE = '0;
    bus.RsE = '0; bus.RtE = '0; bus.RdE = '0; bus.ShamtE = '0;
    bus.ALUControlE = 4'b0010; bus.ALUSrcE = 1'b0; bus.RegDstE = 1'b1;
    bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.MemWriteE = 1'b0;
    bus.MdOpE = 3'b000; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.ResultW = '0;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_aluout"}, bus.ALUOutM, 32'h0);
    check({tag, "_wdata"}, bus.WriteDataM, 32'h0);
    check({tag, "_wreg"}, {27'd0, bus.WriteRegM}, 32'h0);
    check({tag, "_ctrl"}, {29'd0, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'h0);
  endtask

  // Counts consecutive stalled cycles from the current one; bounded so a stuck StallE still ends the run.
  task automatic count_stall(output int n);
    n = 0;
    bubble_bad = 0;
    @(negedge clk);
    while (bus.StallE === 1'b1 && n < 200) begin
      if (n > 0 && (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.ALUOutM !== 32'h0))
        bubble_bad++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic md_run(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    clear_inputs();
    bus.MdOpE = op; bus.RD1E = a; bus.RD2E = b; bus.RegWriteE = 1'b1; bus.RdE = 5'd9;
    count_stall(n);
    check({name, "_stall_cycles"}, n, 33);
    check({name, "_bubbles"}, bubble_bad, 0);
    step();
    check({name, "_no_regwrite"}, {31'd0, bus.RegWriteM}, 32'h0);
    bus.MdOpE = 3'b110;
    step();
    check({name, "_lo"}, bus.ALUOutM, exp_lo);
    check({name, "_mflo_regwrite"}, {31'd0, bus.RegWriteM}, 32'h1);
    bus.MdOpE = 3'b101;
    step();
    check({name, "_hi"}, bus.ALUOutM, exp_hi);
  endtask

  initial begin
    int n;
    vt[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 32'h8000_0000};
    vt[1]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 32'h0000_0001};
    vt[2]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 32'h0000_0000};
    vt[3]  = '{4'b1011, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 5'd4, 32'hF800_0000};
    vt[4]  = '{4'b1100, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 5'd0, 32'h1234_0000};
    vt[5]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd0, 32'h00F0_00F0};
    vt[6]  = '{4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd0, 32'hFFF0_FFF0};
    vt[7]  = '{4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd0, 32'hFF00_FF00};
    vt[8]  = '{4'b0100, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'hFFFF_FFFF};
    vt[9]  = '{4'b0110, 32'h0, 32'h1, 32'h0, 1'b0, 5'd0, 32'hFFFF_FFFF};
    vt[10] = '{4'b1001, 32'h0, 32'h1, 32'h0, 1'b0, 5'd31, 32'h8000_0000};
    vt[11] = '{4'b1010, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 5'd4, 32'h0800_0000};
    vt[12] = '{4'b0101, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0000_0000};
    vt[13] = '{4'b0010, 32'h0000_0010, 32'h5, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h0000_000F};
    vt[14] = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 5'd0, 32'h0000_0001};

    rst_n = 1'b0;
    clear_inputs();
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.RD2E = 32'h55;
    step();
    step();
    check_m_zero("reset");
    check("reset_stall", {31'd0, bus.StallE}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      clear_inputs();
      bus.ALUControlE = vt[i].ctrl; bus.RD1E = vt[i].a; bus.RD2E = vt[i].b;
      bus.SignImmE = vt[i].imm; bus.ALUSrcE = vt[i].src; bus.ShamtE = vt[i].sh;
      bus.RegWriteE = 1'b1; bus.RegDstE = (i % 2 == 1);
      bus.RdE = 5'(i); bus.RtE = 5'(31 - i);
      step();
      check($sformatf("alu_%0d", i), bus.ALUOutM, vt[i].exp);
      check($sformatf("wdata_%0d", i), bus.WriteDataM, vt[i].b);
      check($sformatf("wreg_%0d", i), {27'd0, bus.WriteRegM}, (i % 2 == 1) ? i : 31 - i);
      check($sformatf("regwrite_%0d", i), {31'd0, bus.RegWriteM}, 32'h1);
    end

    clear_inputs();
    bus.RD1E = 32'd2; bus.RD2E = 32'd3; bus.RegWriteE = 1'b1;
    step();
    check("fwd_setup", bus.ALUOutM, 32'd5);
    bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'd7;
    bus.RD1E = 32'd100; bus.RD2E = 32'd200;
    step();
    check("fwd_add", bus.ALUOutM, 32'd12);
    check("fwd_wdata", bus.WriteDataM, 32'd7);
    clear_inputs();
    bus.RD1E = 32'h100; bus.RD2E = 32'h999; bus.ALUSrcE = 1'b1; bus.SignImmE = 32'd4;
    bus.ForwardBE = 2'b01; bus.ResultW = 32'd7; bus.MemWriteE = 1'b1;
    step();
    check("store_addr", bus.ALUOutM, 32'h104);
    check("store_data", bus.WriteDataM, 32'd7);
    check("store_memwrite", {31'd0, bus.MemWriteM}, 32'h1);
    clear_inputs();
    bus.ForwardAE = 2'b11; bus.RD1E = 32'd9; bus.RD2E = 32'd1; bus.ResultW = 32'd50;
    step();
    check("fwd_11_regfile", bus.ALUOutM, 32'd10);

    md_run("mult", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md_run("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu0", 3'b100, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    md_run("divu", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);
    md_run("multu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

    // mfhi arrives while the multu is still iterating: stalls through DONE, then reads the new HI.
    clear_inputs();
    bus.MdOpE = 3'b010; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) step();
    bus.MdOpE = 3'b101; bus.RegWriteE = 1'b1;
    count_stall(n);
    check("mfhi_busy_stall", n, 29);
    step();
    check("mfhi_busy_hi", bus.ALUOutM, 32'hFFFF_FFFE);
    check("mfhi_no_restart", {31'd0, bus.StallE}, 32'h0);
    bus.MdOpE = 3'b110;
    step();
    check("mflo_after_busy", bus.ALUOutM, 32'h0000_0001);

    // Reset in the middle of a multu aborts it and clears HI/LO.
    clear_inputs();
    bus.MdOpE = 3'b010; bus.RD1E = 32'd3; bus.RD2E = 32'd3;
    for (int k = 0; k < 10; k++) step();
    check("pre_reset_stall", {31'd0, bus.StallE}, 32'h1);
    rst_n = 1'b0;
    bus.MdOpE = 3'b000;
    step();
    rst_n = 1'b1;
    check("abort_stall", {31'd0, bus.StallE}, 32'h0);
    check_m_zero("abort");
    bus.MdOpE = 3'b101;
    step();
    check("abort_hi", bus.ALUOutM, 32'h0);
    bus.MdOpE = 3'b110;
    step();
    check("abort_lo", bus.ALUOutM, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the five-stage MIPS pipeline, sitting between the ID/EX register and the memory stage. It resolves operand forwarding, runs the single-cycle ALU, hosts an iterative multiply/divide unit with HI/LO registers, and owns the EX/MEM pipeline register. That register drives `ALUOutM`, `WriteDataM` and `WriteRegM` into the memory stage. While the multiply/divide unit is busy it raises `StallE` to the hazard unit.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `RD1E`, `RD2E` in 32: register-file operands from ID/EX.
- `SignImmE` in 32: sign-extended immediate.
- `RsE`, `RtE`, `RdE` in 5: register indices.
- `ShamtE` in 5: shift amount.
- `ALUControlE` in 4: ALU operation (encoding below).
- `ALUSrcE` in 1: 1 selects `SignImmE` as operand B.
- `RegDstE` in 1: 1 selects `RdE` as destination, 0 selects `RtE`.
- `RegWriteE`, `MemtoRegE`, `MemWriteE` in 1: control bits passed through to MEM.
- `MdOpE` in 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mfhi, 110 mflo; others are treated as none.
- `ForwardAE`, `ForwardBE` in 2: forwarding select. 00 = register file, 01 = `ResultW`, 10 = `ALUOutM`, 11 = register file.
- `ResultW` in 32: writeback result.
- `WriteRegE` out 5: combinational destination index, for the hazard unit.
- `StallE` out 1: combinational; hold IF/ID/ID-EX while high.
- `ALUOutM`, `WriteDataM` out 32: EX/MEM registered result and store data.
- `WriteRegM` out 5: EX/MEM registered destination.
- `RegWriteM`, `MemtoRegM`, `MemWriteM` out 1: EX/MEM registered controls.

## Operation
- **Operand A** = forward mux(`RD1E`, `ForwardAE`).
- **Operand B:** `SrcBFwd` = forward mux(`RD2E`, `ForwardBE`); B = `ALUSrcE` ? `SignImmE` : `SrcBFwd`. `WriteDataM` captures `SrcBFwd`.
- **ALU encoding:**
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB.
  - 0111 SLT (signed, result 0/1), 1000 SLTU.
  - 1001 SLL B by `ShamtE`, 1010 SRL, 1011 SRA.
  - 1100 LUI (B[15:0] << 16).
  - Unused codes give 0.
  - ADD/SUB wrap modulo 2^32; there is no overflow trap.
- **mfhi/mflo:** the EX result is `HI`/`LO` instead of the ALU output.
- **Multiply/divide FSM** with states IDLE, BUSY, DONE and a 5-bit counter.
  - **IDLE:** on an mult/multu/div/divu op, latch operand magnitudes and sign flags, clear the counter, go to BUSY. `StallE`=1 in this cycle.
  - **BUSY:** one shift-add (multiply) or restoring-subtract (divide) step per cycle, 32 steps. `StallE`=1.
    - After step 32: apply sign correction and write HI/LO, then go to DONE.
    - mult: {HI,LO} = 64-bit product.
    - div: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
  - **DONE:** `StallE`=0. The held instruction retires; go to IDLE without restarting.
  - **Divide by zero:** LO=0xFFFFFFFF, HI=dividend; no exception.
- **mfhi/mflo while FSM not IDLE:** `StallE`=1 until IDLE.
- **Bubbles into EX/MEM:** while `StallE`=1, the EX/MEM register loads a bubble (`RegWriteM`=0, `MemWriteM`=0, `MemtoRegM`=0, data 0). mult/div instructions never assert `RegWriteM`.
- **Reset** (`rst_n`=0 at an edge): all EX/MEM outputs 0, HI=LO=0, FSM to IDLE, counter 0. An in-flight multiply/divide is aborted and its HI/LO are discarded.

## Timing
- ALU and mfhi/mflo: 1-cycle latency. Inputs in cycle t appear on the `*M` outputs after the edge ending cycle t.
- Multiply/divide issued in cycle t:
  - `StallE` is high for cycles t..t+32 (33 cycles).
  - HI/LO are written at the edge ending t+32.
  - DONE in t+33; the next instruction enters EX at t+34 and sees the new HI/LO.
- Forwarding and `StallE` are combinational within the cycle.
- `ALUOutM` fed back via select 10 is the value registered at the previous edge.

## Test plan
- **ALU sweep:** ADD 0x7FFFFFFF+1 -> `ALUOutM`=0x80000000. SLT -1,1 -> 1. SLTU -1,1 -> 0. SRA 0x80000000 by 4 -> 0xF8000000. LUI imm 0x1234 -> 0x12340000.
- **Forwarding:** `ForwardAE`=10 with prior `ALUOutM`=5, `ForwardBE`=01 with `ResultW`=7, ADD -> 12. A store with `ForwardBE`=01 has `WriteDataM`=7.
- **mult:** -3 × 5 -> `StallE` high exactly 33 cycles, bubbles into MEM, HI=0xFFFFFFFF, LO=0xFFFFFFF1. A following mflo returns 0xFFFFFFF1.
- **div:** -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- **mfhi during BUSY:** stalls until DONE, then returns the new HI.
- **Reset:** assert `rst_n`=0 at cycle 10 of a multu -> next cycle `StallE`=0, HI=LO=0, all `*M` outputs 0.
